keypad_matrix_scanner: RTL and testbench

//  Parametrised R x C matrix-keypad scanner: drives rows one at a time, samples columns,

---
 rtl/keypad_matrix_scanner_pkg.sv | 33 +++
 rtl/keypad_matrix_scanner_key_fifo.sv | 65 ++++++
 rtl/keypad_matrix_scanner.sv | 242 ++++++++++++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared types and elaboration-time helpers for the keypad matrix scanner.
package keypad_matrix_scanner_pkg;

    // Key-event sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } scan_state_e;

    // Ceiling log2, usable in parameter expressions
    function automatic int clog2_f(input int value);
        int width;
        int span;
        width = 0;
        span  = 1;
        while (span < value) begin
            span  = span * 2;
            width = width + 1;
        end
        return width;
    endfunction

    // Width of a key code r*COLS + c (never narrower than one bit)
    function automatic int code_width_f(input int rows, input int cols);
        return (rows * cols > 1) ? clog2_f(rows * cols) : 1;
    endfunction

    function automatic int max_f(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/keypad_matrix_scanner_key_fifo.sv
// Small first-word-fall-through event queue; the head is always visible on dout_o.
module keypad_matrix_scanner_key_fifo
    import keypad_matrix_scanner_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             valid_o,
    output logic             drop_o
);

    localparam int AW = clog2_f(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             empty, full, do_push, do_pop;

    // Extra wrap bit distinguishes full from empty when the indices match
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty;
    // A pop in the same cycle frees a slot, so a push on full still lands
    assign do_push = push_i && (!full || do_pop);
    assign drop_o  = push_i && !do_push;
    assign valid_o = !empty;
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance for accepted pushes and pops
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // Pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; cleared on reset so the head reads as code 0 afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Matrix keypad scanner: row strobing, whole-matrix debounce, single-key
// decode, press/auto-repeat sequencing and a small key-event queue.
module keypad_matrix_scanner
    import keypad_matrix_scanner_pkg::*;
#(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE     = 3,
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_EN    = 1,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10,
    localparam int KW          = code_width_f(ROWS, COLS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [COLS-1:0] col,
    output logic [ROWS-1:0] row,
    output logic            key_valid,
    output logic [KW-1:0]   key_code,
    input  logic            key_rd,
    output logic            key_held,
    output logic            overflow,
    input  logic            clr_ovf
);

    localparam int NCELL = ROWS * COLS;
    localparam int RW    = clog2_f(ROWS);
    localparam int DW    = clog2_f(SCAN_DIV);
    localparam int SW    = clog2_f(DEBOUNCE + 1);
    localparam int CW    = clog2_f(max_f(REPEAT_DELAY, REPEAT_RATE) + 1);
    localparam bit REP_ON = (REPEAT_EN != 0);
    localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

    // Scan state
    logic             run_q, run_d;
    logic [RW-1:0]    row_idx_q, row_idx_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [NCELL-1:0] snap_q, snap_d;
    logic             last_dwell, last_row, scan_done;

    // Debounce state
    logic [NCELL-1:0] prev_q, prev_d;
    logic [NCELL-1:0] stable_q, stable_d;
    logic [SW-1:0]    stable_cnt_q, stable_cnt_d;
    logic             tick_q;

    // Decode
    logic [1:0]       ones;
    logic [KW-1:0]    dec_code;
    logic             single, same_key;

    // Event sequencer
    scan_state_e      state_q, state_d;
    logic [CW-1:0]    rcnt_q, rcnt_d;
    logic [KW-1:0]    held_code_q, held_code_d;
    logic             push;

    // Queue and overflow
    logic             drop;
    logic             ovf_q, ovf_d;

    assign last_dwell = run_q && (dwell_q == DW'(SCAN_DIV - 1));
    assign last_row   = (row_idx_q == RW'(ROWS - 1));
    assign scan_done  = last_dwell && last_row;

    // Per-row drive and snapshot capture on the last dwell cycle of that row
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        assign row[gi] = ~(run_q && (row_idx_q == RW'(gi)));
        assign snap_d[gi*COLS +: COLS] = (last_dwell && (row_idx_q == RW'(gi))) ?
                                         ~col : snap_q[gi*COLS +: COLS];
    end

    // Dwell counter and row index; rows stay released until the first cycle after reset
    always_comb begin
        run_d     = 1'b1;
        row_idx_d = row_idx_q;
        dwell_d   = dwell_q;
        if (run_q) begin
            if (last_dwell) begin
                dwell_d   = '0;
                row_idx_d = last_row ? '0 : row_idx_q + RW'(1);
            end else begin
                dwell_d = dwell_q + DW'(1);
            end
        end
    end

    // Debounce: count consecutive identical full scans, including the row just sampled
    always_comb begin
        prev_d       = prev_q;
        stable_d     = stable_q;
        stable_cnt_d = stable_cnt_q;
        if (scan_done) begin
            if (snap_d == prev_q) begin
                if (stable_cnt_q != SW'(DEBOUNCE)) stable_cnt_d = stable_cnt_q + SW'(1);
            end else begin
                stable_cnt_d = SW'(1);
            end
            prev_d = snap_d;
            if (stable_cnt_d == SW'(DEBOUNCE)) stable_d = snap_d;
        end
    end

    // Scan and debounce registers; tick_q lets the sequencer see the updated snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q        <= 1'b0;
            row_idx_q    <= '0;
            dwell_q      <= '0;
            snap_q       <= '0;
            prev_q       <= '0;
            stable_q     <= '0;
            stable_cnt_q <= '0;
            tick_q       <= 1'b0;
        end else begin
            run_q        <= run_d;
            row_idx_q    <= row_idx_d;
            dwell_q      <= dwell_d;
            snap_q       <= snap_d;
            prev_q       <= prev_d;
            stable_q     <= stable_d;
            stable_cnt_q <= stable_cnt_d;
            tick_q       <= scan_done;
        end
    end

    // Single-key decode; two or more closed switches (ghosting) decode as no key
    always_comb begin
        ones     = 2'd0;
        dec_code = '0;
        for (int i = 0; i < NCELL; i++) begin
            if (stable_q[i]) begin
                if (ones != 2'd2) ones = ones + 2'd1;
                dec_code = KW'(i);
            end
        end
    end

    assign single   = (ones == 2'd1);
    assign same_key = single && (dec_code == held_code_q);
    assign key_held = single;

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rcnt_q      <= '0;
            held_code_q <= '0;
        end else begin
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            held_code_q <= held_code_d;
        end
    end

    // Sequencer next state, evaluated once per completed scan
    always_comb begin
        state_d     = state_q;
        rcnt_d      = rcnt_q;
        held_code_d = held_code_q;
        if (tick_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (single) begin
                        state_d     = ST_DELAY;
                        rcnt_d      = '0;
                        held_code_d = dec_code;
                    end
                end
                ST_DELAY: begin
                    if (!same_key) begin
                        state_d = ST_IDLE;
                    end else if (rcnt_q == DELAY_LAST) begin
                        // Without repeat the counter parks here until release
                        if (REP_ON) begin
                            state_d = ST_REPEAT;
                            rcnt_d  = '0;
                        end
                    end else begin
                        rcnt_d = rcnt_q + CW'(1);
                    end
                end
                ST_REPEAT: begin
                    if (!same_key) begin
                        state_d = ST_IDLE;
                    end else if (rcnt_q == RATE_LAST) begin
                        rcnt_d = '0;
                    end else begin
                        rcnt_d = rcnt_q + CW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Sequencer outputs: event push for press and repeat instants
    always_comb begin
        push = 1'b0;
        if (tick_q) begin
            case (state_q)
                ST_IDLE:   push = single;
                ST_DELAY:  push = REP_ON && same_key && (rcnt_q == DELAY_LAST);
                ST_REPEAT: push = same_key && (rcnt_q == RATE_LAST);
                default:   push = 1'b0;
            endcase
        end
    end

    keypad_matrix_scanner_key_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (KW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (dec_code),
        .pop_i   (key_rd),
        .dout_o  (key_code),
        .valid_o (key_valid),
        .drop_o  (drop)
    );

    // Sticky overflow; a drop in the same cycle as a clear keeps it set
    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;
    end

    // Overflow register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign overflow = ovf_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench: two scanners (auto-repeat on / off) watching one simulated keypad,
// with queued expected events checked by an independent output monitor.
module tb_keypad_matrix_scanner;

    typedef struct {
        int code;
        int scan;   // scan index in which the event must appear; -1 = any time
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] keys;
    logic [3:0]  col_a, col_b, row_a, row_b;
    logic        key_valid_a, key_valid_b, key_rd_a, key_rd_b;
    logic [3:0]  key_code_a, key_code_b;
    logic        key_held_a, key_held_b, overflow_a, overflow_b;
    logic        clr_ovf, rd_force_a, pop_en_a;

    int   checks;
    int   failures;
    int   scan_no;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A (repeat on) is popped on demand; B (repeat off) always drains immediately
    assign key_rd_a = (pop_en_a & key_valid_a) | rd_force_a;
    assign key_rd_b = key_valid_b;

    // Passive keypad: a closed switch pulls its column low while its row is driven
    always_comb begin
        col_a = 4'hF;
        col_b = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c]) begin
                    if (!row_a[r]) col_a[c] = 1'b0;
                    if (!row_b[r]) col_b[c] = 1'b0;
                end
            end
        end
    end

    keypad_matrix_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(2), .FIFO_DEPTH(4),
        .REPEAT_EN(1), .REPEAT_DELAY(3), .REPEAT_RATE(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .col(col_a), .row(row_a),
        .key_valid(key_valid_a), .key_code(key_code_a), .key_rd(key_rd_a),
        .key_held(key_held_a), .overflow(overflow_a), .clr_ovf(clr_ovf)
    );

    keypad_matrix_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(2), .FIFO_DEPTH(4),
        .REPEAT_EN(0), .REPEAT_DELAY(3), .REPEAT_RATE(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .col(col_b), .row(row_b),
        .key_valid(key_valid_b), .key_code(key_code_b), .key_rd(key_rd_b),
        .key_held(key_held_b), .overflow(overflow_b), .clr_ovf(1'b0)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d scan=%0d", name, act, exp, scan_no);
        end else begin
            $display("ok   %s value=%0d scan=%0d", name, act, scan_no);
        end
    endtask

    task automatic score(input string name, input int code, input exp_t e);
        checks++;
        if (code != e.code || (e.scan >= 0 && scan_no != e.scan)) begin
            failures++;
            $display("FAIL %s actual code=%0d scan=%0d expected code=%0d scan=%0d",
                     name, code, scan_no, e.code, e.scan);
        end else begin
            $display("ok   %s code=%0d scan=%0d", name, code, scan_no);
        end
    endtask

    task automatic exp_a(input int code, input int scan);
        exp_t e;
        e.code = code;
        e.scan = scan;
        q_a.push_back(e);
    endtask

    task automatic exp_b(input int code, input int scan);
        exp_t e;
        e.code = code;
        e.scan = scan;
        q_b.push_back(e);
    endtask

    // Advance one full 16-cycle scan, optionally pulsing clr_ovf / forced pop on its first edge
    task automatic next_scan_pulse(input bit do_clr, input bit do_rd);
        clr_ovf    = do_clr;
        rd_force_a = do_rd;
        @(posedge clk);
        #1;
        clr_ovf    = 1'b0;
        rd_force_a = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        scan_no++;
    endtask

    task automatic next_scan();
        next_scan_pulse(1'b0, 1'b0);
    endtask

    task automatic hold(input logic [15:0] k, input int n);
        keys = k;
        repeat (n) next_scan();
    endtask

    // Monitor: every event taken from either queue is matched against the scoreboard
    always @(negedge clk) begin
        if (rst_n && key_valid_a && key_rd_a) begin
            if (q_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL evA unexpected code=%0d scan=%0d", key_code_a, scan_no);
            end else begin
                ea = q_a.pop_front();
                score("evA", int'(key_code_a), ea);
            end
        end
        if (rst_n && key_valid_b && key_rd_b) begin
            if (q_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL evB unexpected code=%0d scan=%0d", key_code_b, scan_no);
            end else begin
                eb = q_b.pop_front();
                score("evB", int'(key_code_b), eb);
            end
        end
    end

    int k;
    int ovf_codes[5] = '{1, 2, 3, 4, 7};

    initial begin
        checks     = 0;
        failures   = 0;
        scan_no    = 0;
        rst_n      = 1'b0;
        keys       = '0;
        clr_ovf    = 1'b0;
        rd_force_a = 1'b0;
        pop_en_a   = 1'b1;

        // 1: reset state, then the row walk
        repeat (3) @(posedge clk);
        #1;
        chk("rst_row_a", int'(row_a), 15);
        chk("rst_row_b", int'(row_b), 15);
        chk("rst_valid_a", int'(key_valid_a), 0);
        chk("rst_code_a", int'(key_code_a), 0);
        chk("rst_held_a", int'(key_held_a), 0);
        chk("rst_ovf_a", int'(overflow_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        scan_no = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk("row_walk", int'(row_a), 15 ^ (1 << ((i / 4) % 4)));
        end
        @(posedge clk);
        #1;
        scan_no = 2;

        // 2: r2c1 held 10 scans
        k = scan_no;
        exp_b(9, k + 2);
        exp_a(9, k + 2); exp_a(9, k + 5); exp_a(9, k + 7); exp_a(9, k + 9); exp_a(9, k + 11);
        hold(16'h0200, 2);
        chk("held_r2c1", int'(key_held_b), 1);
        hold(16'h0200, 8);
        hold(16'h0000, 1);
        chk("held_release1", int'(key_held_b), 1);
        hold(16'h0000, 1);
        chk("held_release2", int'(key_held_b), 0);

        // 3: bouncing r3c2 for five scans, then settled
        k = scan_no;
        exp_a(14, k + 6);
        exp_b(14, k + 6);
        for (int i = 0; i < 5; i++) hold((i % 2 == 0) ? 16'h4000 : 16'h0000, 1);
        chk("held_bounce", int'(key_held_a), 0);
        hold(16'h4000, 2);
        chk("held_settled", int'(key_held_a), 1);
        hold(16'h0000, 2);

        // 4: r0c0 held 9 scans - press, +3 scans, then every 2 scans on A
        k = scan_no;
        exp_b(0, k + 2);
        exp_a(0, k + 2); exp_a(0, k + 5); exp_a(0, k + 7); exp_a(0, k + 9);
        hold(16'h0001, 9);
        hold(16'h0000, 2);

        // 5: ghost pair r1c1+r1c2, then r1c1 alone
        k = scan_no;
        exp_a(5, k + 6);
        exp_b(5, k + 6);
        hold(16'h0060, 4);
        chk("held_ghost", int'(key_held_a), 0);
        hold(16'h0020, 2);
        chk("held_after_ghost", int'(key_held_a), 1);
        hold(16'h0020, 1);
        hold(16'h0000, 2);

        // 6: five presses into A without reading; the fifth is dropped
        pop_en_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            k = scan_no;
            exp_b(ovf_codes[i], k + 2);
            if (i < 4) exp_a(ovf_codes[i], -1);
            hold(16'(1 << ovf_codes[i]), 3);
            hold(16'h0000, 2);
        end
        chk("ovf_set_a", int'(overflow_a), 1);
        chk("ovf_clear_b", int'(overflow_b), 0);
        chk("valid_full_a", int'(key_valid_a), 1);
        next_scan_pulse(1'b1, 1'b0);
        chk("ovf_cleared", int'(overflow_a), 0);

        // Pop coincident with a push into the full queue: both must take effect
        k = scan_no;
        exp_b(8, k + 2);
        exp_a(8, -1);
        hold(16'h0100, 2);
        next_scan_pulse(1'b0, 1'b1);
        hold(16'h0000, 2);
        chk("ovf_after_swap", int'(overflow_a), 0);
        pop_en_a = 1'b1;
        next_scan();

        chk("pending_a", q_a.size(), 0);
        chk("pending_b", q_b.size(), 0);
        chk("drained_a", int'(key_valid_a), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
